// File: rtl/div_16b_seq.sv
// Iterative restoring divider: one quotient bit per clock on operand magnitudes,
// with sign fix-up on exit and a start/busy/done handshake.
module div_16b_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             Signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Quot,
   output logic [WIDTH-1:0] Rem,
   output logic             DivByZero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   rem;
   logic             qneg;
   logic             rneg;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;
   logic             borrow;

   // rem never exceeds the divisor, so the top bit of shifted is always zero and
   // the borrow out of the wide subtract is a clean "shifted < divisor" test.
   always_comb begin
      a_mag   = (Signed && A[WIDTH-1]) ? (~A + ONE) : A;
      b_mag   = (Signed && B[WIDTH-1]) ? (~B + ONE) : B;
      shifted = {rem, dvd[WIDTH-1]};
      diff    = shifted - {2'b00, dvs};
      borrow  = diff[WIDTH+1];
   end

   // NOTE: every signal driven here gets a default first, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (B == '0) ? DONE : CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (cnt == CW'(1)) state_nxt = FIX;
         end
         FIX: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: all clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         dvd       <= '0;
         dvs       <= '0;
         rem       <= '0;
         qneg      <= 1'b0;
         rneg      <= 1'b0;
         Quot      <= '0;
         Rem       <= '0;
         DivByZero <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  if (B == '0) begin
                     Quot      <= '1;
                     Rem       <= A;
                     DivByZero <= 1'b1;
                  end else begin
                     dvd  <= a_mag;
                     dvs  <= b_mag;
                     rem  <= '0;
                     qneg <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                     rneg <= Signed & A[WIDTH-1];
                     cnt  <= CW'(WIDTH);
                  end
               end
            end
            CALC: begin
               rem <= borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
               dvd <= {dvd[WIDTH-2:0], ~borrow};
               cnt <= cnt - CW'(1);
            end
            FIX: begin
               Quot      <= qneg ? (~dvd + ONE) : dvd;
               Rem       <= rneg ? (~rem[WIDTH-1:0] + ONE) : rem[WIDTH-1:0];
               DivByZero <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_16b_seq.sv
// Self-checking bench for div_16b_seq: directed plan cases, handshake corners,
// mid-operation reset and randomized operands against an integer-arithmetic model.
module tb_div_16b_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sgn;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic [15:0] Quot;
   logic [15:0] Rem;
   logic        DivByZero;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
   } vec_t;

   div_16b_seq #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .Signed    (sgn),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .done      (done),
      .Quot      (Quot),
      .Rem       (Rem),
      .DivByZero (DivByZero)
   );

   always #5 clk = ~clk;

   // Reference: plain integer division; SV int '/' and '%' truncate toward zero
   // with the remainder taking the dividend's sign.
   function automatic void ref_div(input logic [15:0] a, input logic [15:0] b, input logic s,
                                   output logic [15:0] q, output logic [15:0] r, output logic dz);
      int ai;
      int bi;
      int qi;
      int ri;
      if (b == 16'd0) begin
         q  = 16'hFFFF;
         r  = a;
         dz = 1'b1;
      end else begin
         if (s) begin
            ai = int'($signed(a));
            bi = int'($signed(b));
         end else begin
            ai = int'(a);
            bi = int'(b);
         end
         qi = ai / bi;
         ri = ai % bi;
         q  = qi[15:0];
         r  = ri[15:0];
         dz = 1'b0;
      end
   endfunction

   // Called at a negedge. Returns at the negedge where done is high (or after a
   // 40-edge budget). lat counts edges after the accepting edge; bcnt counts
   // sampled busy-high cycles before done. While waiting, operands are scrambled
   // and start is pulsed with A=1,B=1 at cycle glitch_at.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input int glitch_at, output int lat, output int bcnt);
      A     = a;
      B     = b;
      sgn   = s;
      start = 1'b1;
      @(posedge clk);
      lat  = 0;
      bcnt = 0;
      @(negedge clk);
      start = 1'b0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         A     = 16'($urandom);
         B     = 16'($urandom);
         sgn   = 1'($urandom);
         start = (lat == glitch_at);
         if (start) begin
            A = 16'd1;
            B = 16'd1;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      sgn   = 1'b0;
      A     = 16'h1234;
      B     = 16'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({busy, done, Quot, Rem, DivByZero} !== 35'd0) begin
         n_err++;
         $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b, expected all zero",
                  busy, done, Quot, Rem, DivByZero);
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_err++;
         $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", busy, done);
      end
   endtask

   task automatic test_directed();
      vec_t        v[$];
      int          lat;
      int          bcnt;
      int          exp_lat;
      logic [15:0] held_q;
      v.push_back({16'd100,   16'd7,    1'b0, 16'd14,   16'd2,    1'b0});
      v.push_back({16'hFFF9,  16'd2,    1'b1, 16'hFFFD, 16'hFFFF, 1'b0});
      v.push_back({16'h0007,  16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0});
      v.push_back({16'h0007,  16'h0000, 1'b0, 16'hFFFF, 16'h0007, 1'b1});
      v.push_back({16'hFFFF,  16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0});
      v.push_back({16'h8000,  16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0});
      v.push_back({16'h0005,  16'h0009, 1'b0, 16'h0000, 16'h0005, 1'b0});
      v.push_back({16'hFFF9,  16'h0000, 1'b1, 16'hFFFF, 16'hFFF9, 1'b1});
      v.push_back({16'h8000,  16'h0002, 1'b0, 16'h4000, 16'h0000, 1'b0});
      v.push_back({16'h8000,  16'h0002, 1'b1, 16'hC000, 16'h0000, 1'b0});
      foreach (v[i]) begin
         do_op(v[i].a, v[i].b, v[i].s, -1, lat, bcnt);
         exp_lat = v[i].dz ? 0 : 17;
         n_cmp++;
         if ({Quot, Rem, DivByZero} !== {v[i].q, v[i].r, v[i].dz}) begin
            n_err++;
            $display("FAIL directed[%0d] result: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
                     i, Quot, Rem, DivByZero, v[i].q, v[i].r, v[i].dz);
         end
         n_cmp++;
         if (lat !== exp_lat || bcnt !== exp_lat || busy !== 1'b0) begin
            n_err++;
            $display("FAIL directed[%0d] timing: got latency=%0d busy_cycles=%0d busy_at_done=%b, expected %0d %0d 0",
                     i, lat, bcnt, busy, exp_lat, exp_lat);
         end
         held_q = Quot;
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if (done !== 1'b0 || Quot !== held_q) begin
            n_err++;
            $display("FAIL directed[%0d] done_pulse: got done=%b q=%h, expected done=0 q=%h",
                     i, done, Quot, held_q);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int lat;
      int bcnt;
      do_op(16'd100, 16'd7, 1'b0, 5, lat, bcnt);
      n_cmp++;
      if ({Quot, Rem, DivByZero, lat} !== {16'd14, 16'd2, 1'b0, 32'd17}) begin
         n_err++;
         $display("FAIL start_while_busy: got q=%0d r=%0d dz=%b latency=%0d, expected q=14 r=2 dz=0 latency=17",
                  Quot, Rem, DivByZero, lat);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat;
      int bcnt;
      do_op(16'd100, 16'd7, 1'b0, -1, lat, bcnt);
      n_cmp++;
      if ({Quot, Rem} !== {16'd14, 16'd2}) begin
         n_err++;
         $display("FAIL b2b_first: got q=%0d r=%0d, expected q=14 r=2", Quot, Rem);
      end
      A     = 16'd20;
      B     = 16'd3;
      sgn   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({busy, done, Quot, Rem} !== {1'b0, 1'b0, 16'd14, 16'd2}) begin
         n_err++;
         $display("FAIL b2b_start_in_done: got busy=%b done=%b q=%0d r=%0d, expected busy=0 done=0 q=14 r=2",
                  busy, done, Quot, Rem);
      end
      do_op(16'd20, 16'd3, 1'b0, -1, lat, bcnt);
      n_cmp++;
      if ({Quot, Rem, DivByZero, lat} !== {16'd6, 16'd2, 1'b0, 32'd17}) begin
         n_err++;
         $display("FAIL b2b_second: got q=%0d r=%0d dz=%b latency=%0d, expected q=6 r=2 dz=0 latency=17",
                  Quot, Rem, DivByZero, lat);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      int lat;
      int bcnt;
      int pulses;
      A     = 16'd100;
      B     = 16'd7;
      sgn   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({busy, done, Quot, Rem, DivByZero} !== 35'd0) begin
         n_err++;
         $display("FAIL reset_mid_op: got busy=%b done=%b q=%h r=%h dz=%b, expected all zero",
                  busy, done, Quot, Rem, DivByZero);
      end
      pulses = 0;
      repeat (25) begin
         @(posedge clk);
         @(negedge clk);
         if (done || busy) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin
         n_err++;
         $display("FAIL reset_mid_op_quiet: got %0d busy/done cycles, expected 0", pulses);
      end
      do_op(16'd50, 16'd5, 1'b0, -1, lat, bcnt);
      n_cmp++;
      if ({Quot, Rem, DivByZero, lat} !== {16'd10, 16'd0, 1'b0, 32'd17}) begin
         n_err++;
         $display("FAIL reset_mid_op_next: got q=%0d r=%0d dz=%b latency=%0d, expected q=10 r=0 dz=0 latency=17",
                  Quot, Rem, DivByZero, lat);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic [15:0] eq;
      logic [15:0] er;
      logic        edz;
      int          lat;
      int          bcnt;
      int          exp_lat;
      for (int i = 0; i < 60; i++) begin
         a = 16'($urandom);
         s = 1'($urandom);
         case ($urandom_range(0, 7))
            0:       b = 16'd0;
            1:       b = 16'($urandom_range(1, 15));
            2:       b = 16'hFFFF;
            3:       b = 16'h8000;
            default: b = 16'($urandom);
         endcase
         if (i % 10 == 0) a = 16'h8000;
         ref_div(a, b, s, eq, er, edz);
         exp_lat = edz ? 0 : 17;
         do_op(a, b, s, int'($urandom_range(0, 16)), lat, bcnt);
         n_cmp++;
         if ({Quot, Rem, DivByZero} !== {eq, er, edz} || lat !== exp_lat) begin
            n_err++;
            $display("FAIL random[%0d] %h/%h s=%b: got q=%h r=%h dz=%b latency=%0d, expected q=%h r=%h dz=%b latency=%0d",
                     i, a, b, s, Quot, Rem, DivByZero, lat, eq, er, edz, exp_lat);
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      sgn   = 1'b0;
      A     = '0;
      B     = '0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_op();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
